// File: rtl/control_word_sequencer.sv
// Control-word sequencer for the DE0 datapath test: debounces the push-buttons,
// records control words from the switches and replays them one step at a time.

module cws_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_a;
    logic             sync_b;
    logic             cand;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // cand tracks the synchronised level; any change restarts the stability count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cand   <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b != cand) begin
                cand <= sync_b;
                cnt  <= '0;
            end else if (cand != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= cand;
                    press <= cand;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module control_word_sequencer #(
    parameter int CW_WIDTH        = 37,
    parameter int DEPTH           = 16,
    parameter int ADDR_W          = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CW_WIDTH-1:0] sw_cw,
    input  logic                btn_load,
    input  logic                btn_step,
    input  logic                mode_run,
    output logic [CW_WIDTH-1:0] control_word,
    output logic                step_en,
    output logic [ADDR_W:0]     seq_len,
    output logic [ADDR_W-1:0]   rd_ptr,
    output logic                full,
    output logic                wrapped
);
    typedef enum logic [1:0] {S_LOAD, S_RUN, S_ISSUE} state_t;

    state_t              state;
    state_t              ret_state;
    logic                load_p;
    logic                step_p;
    logic                mode_a;
    logic                mode_sync;
    logic                mem_we;
    logic [ADDR_W:0]     rd_next;
    logic [CW_WIDTH-1:0] mem [DEPTH];

    cws_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clock (clock),
        .reset (reset),
        .raw   (btn_load),
        .press (load_p)
    );

    cws_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clock (clock),
        .reset (reset),
        .raw   (btn_step),
        .press (step_p)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_a    <= 1'b0;
            mode_sync <= 1'b0;
        end else begin
            mode_a    <= mode_run;
            mode_sync <= mode_a;
        end
    end

    assign full    = (seq_len == (ADDR_W + 1)'(DEPTH));
    // A simultaneous step press wins over a load press
    assign mem_we  = (state == S_LOAD) && load_p && !step_p && !full;
    assign rd_next = {1'b0, rd_ptr} + 1'b1;

    // Storage carries no reset so it maps onto plain RAM
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[seq_len[ADDR_W-1:0]] <= sw_cw;
        end
    end

    // ISSUE sits between the control-word update and step_en, giving a full setup cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_LOAD;
            ret_state    <= S_LOAD;
            control_word <= '0;
            step_en      <= 1'b0;
            seq_len      <= '0;
            rd_ptr       <= '0;
            wrapped      <= 1'b0;
        end else begin
            step_en <= 1'b0;
            wrapped <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (step_p) begin
                        control_word <= sw_cw;
                        ret_state    <= S_LOAD;
                        state        <= S_ISSUE;
                    end else begin
                        if (mem_we) begin
                            seq_len <= seq_len + 1'b1;
                        end
                        if (mode_sync) begin
                            state  <= S_RUN;
                            rd_ptr <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (step_p && seq_len != '0) begin
                        control_word <= mem[rd_ptr];
                        if (rd_next == seq_len) begin
                            rd_ptr  <= '0;
                            wrapped <= 1'b1;
                        end else begin
                            rd_ptr <= rd_next[ADDR_W-1:0];
                        end
                        ret_state <= S_RUN;
                        state     <= S_ISSUE;
                    end else if (!mode_sync) begin
                        state <= S_LOAD;
                    end
                end
                S_ISSUE: begin
                    step_en <= 1'b1;
                    state   <= ret_state;
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_control_word_sequencer.sv
// Scoreboard bench for control_word_sequencer: expected step responses are queued
// by the stimulus and checked by a monitor on every step_en pulse.

module tb_control_word_sequencer;
    localparam int CW = 37;
    localparam int DB = 4;

    typedef struct {
        logic [CW-1:0] cw;
        logic [3:0]    rd;
        logic          wr;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] sw_cw = '0;
    logic          btn_load = 1'b0;
    logic          btn_step = 1'b0;
    logic          mode_run = 1'b0;
    logic [CW-1:0] control_word;
    logic          step_en;
    logic [4:0]    seq_len;
    logic [3:0]    rd_ptr;
    logic          full;
    logic          wrapped;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            step_count = 0;
    int            step_cyc = 0;
    exp_t          exp_q[$];
    logic [CW-1:0] prev_cw = '0;
    logic          prev_wrapped = 1'b0;

    localparam logic [CW-1:0] BASE = 37'h10_0000_0000;

    control_word_sequencer #(
        .CW_WIDTH(CW), .DEPTH(16), .ADDR_W(4), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sw_cw        (sw_cw),
        .btn_load     (btn_load),
        .btn_step     (btn_step),
        .mode_run     (mode_run),
        .control_word (control_word),
        .step_en      (step_en),
        .seq_len      (seq_len),
        .rd_ptr       (rd_ptr),
        .full         (full),
        .wrapped      (wrapped)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc++;

    // Monitor: every step_en pulse must match the oldest queued expectation
    always @(negedge clock) begin
        exp_t e;
        if (step_en === 1'b1) begin
            step_count++;
            step_cyc = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_step_en: got step_en=1 cw=%h, expected no pulse", control_word);
            end else begin
                e = exp_q.pop_front();
                if (control_word !== e.cw || prev_cw !== e.cw || rd_ptr !== e.rd || prev_wrapped !== e.wr) begin
                    miscompares++;
                    $display("[TB] FAIL step_response: got cw=%h cw_before=%h rd_ptr=%0d wrapped_before=%b, expected cw=%h rd_ptr=%0d wrapped=%b",
                             control_word, prev_cw, rd_ptr, prev_wrapped, e.cw, e.rd, e.wr);
                end
            end
        end
        prev_cw      = control_word;
        prev_wrapped = wrapped;
    end

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    task automatic press_button(input bit is_step);
        if (is_step) btn_step = 1'b1;
        else         btn_load = 1'b1;
        repeat (12) @(negedge clock);
        btn_step = 1'b0;
        btn_load = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clock);
        check_output(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string name);
        check_output({name, "_cw"}, 64'(control_word), 64'd0);
        check_output({name, "_step_en"}, 64'(step_en), 64'd0);
        check_output({name, "_seq_len"}, 64'(seq_len), 64'd0);
        check_output({name, "_rd_ptr"}, 64'(rd_ptr), 64'd0);
        check_output({name, "_full"}, 64'(full), 64'd0);
        check_output({name, "_wrapped"}, 64'(wrapped), 64'd0);
    endtask

    initial begin
        int base_count;
        int rise_cyc;
        bit seen;

        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_values("reset");

        // 1: bouncing step button, then held high
        sw_cw = 37'h1_2345_6789;
        exp_q.push_back('{37'h1_2345_6789, 4'd0, 1'b0});
        base_count = step_count;
        for (int i = 0; i < 10; i++) begin
            btn_step = (i % 2 == 0);
            repeat (2) @(negedge clock);
        end
        btn_step = 1'b1;
        rise_cyc = cyc;
        for (int i = 0; i < 40 && step_count == base_count; i++) @(negedge clock);
        repeat (15) @(negedge clock);
        check_output("bounce_pulse_count", 64'(step_count - base_count), 64'd1);
        vectors++;
        if (step_cyc - rise_cyc < DB || step_cyc - rise_cyc > 14) begin
            miscompares++;
            $display("[TB] FAIL bounce_latency: got %0d cycles, expected %0d..14", step_cyc - rise_cyc, DB);
        end
        btn_step = 1'b0;
        repeat (15) @(negedge clock);
        wait_drain("bounce_drain");

        // 2: manual pass-through in LOAD
        sw_cw = 37'h0_0000_0018;
        exp_q.push_back('{37'd24, 4'd0, 1'b0});
        press_button(1'b1);
        wait_drain("manual_drain");
        check_output("manual_seq_len", 64'(seq_len), 64'd0);

        // 3: load A,B,C and replay four steps
        sw_cw = 37'h0_0000_000A; press_button(1'b0);
        sw_cw = 37'h0_0000_000B; press_button(1'b0);
        sw_cw = 37'h0_0000_000C; press_button(1'b0);
        check_output("abc_seq_len", 64'(seq_len), 64'd3);
        mode_run = 1'b1;
        repeat (4) @(negedge clock);
        exp_q.push_back('{37'h0_0000_000A, 4'd1, 1'b0});
        exp_q.push_back('{37'h0_0000_000B, 4'd2, 1'b0});
        exp_q.push_back('{37'h0_0000_000C, 4'd0, 1'b1});
        exp_q.push_back('{37'h0_0000_000A, 4'd1, 1'b0});
        for (int i = 0; i < 4; i++) press_button(1'b1);
        wait_drain("abc_drain");
        check_output("abc_rd_ptr", 64'(rd_ptr), 64'd1);

        // 5: RUN with nothing stored
        reset = 1'b0;
        #1;
        check_reset_values("reset_pulse");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        sw_cw = 37'h0_5555_AAAA;
        press_button(1'b1);
        check_output("empty_run_cw", 64'(control_word), 64'd0);
        check_output("empty_run_rd_ptr", 64'(rd_ptr), 64'd0);
        press_button(1'b0);
        check_output("run_load_ignored", 64'(seq_len), 64'd0);
        mode_run = 1'b0;
        repeat (4) @(negedge clock);

        // 4: fill to DEPTH, one extra press dropped
        for (int i = 1; i <= 17; i++) begin
            sw_cw = BASE | CW'(i);
            press_button(1'b0);
            if (i == 15) begin
                check_output("fill15_seq_len", 64'(seq_len), 64'd15);
                check_output("fill15_full", 64'(full), 64'd0);
            end
        end
        check_output("fill_seq_len", 64'(seq_len), 64'd16);
        check_output("fill_full", 64'(full), 64'd1);
        mode_run = 1'b1;
        repeat (4) @(negedge clock);
        for (int k = 1; k <= 17; k++) begin
            exp_q.push_back('{BASE | CW'(((k - 1) % 16) + 1), 4'(k % 16), (k == 16)});
        end
        for (int k = 0; k < 17; k++) press_button(1'b1);
        wait_drain("fill_replay_drain");

        // 6: reset between control_word update and step_en
        btn_step = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (control_word === (BASE | CW'(2))) seen = 1'b1;
        end
        check_output("midstep_cw_update", 64'(seen), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        btn_step = 1'b0;
        mode_run = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check_output("after_reset_seq_len", 64'(seq_len), 64'd0);
        check_output("after_reset_full", 64'(full), 64'd0);
        sw_cw = 37'h0_ABCD_0123;
        exp_q.push_back('{37'h0_ABCD_0123, 4'd0, 1'b0});
        press_button(1'b1);
        wait_drain("after_reset_drain");

        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
